// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold/shift/rotate/arith-shift/load plus an optional
// LSB-first burst serialiser, present only when UNIV_SHIFT_REG_BURST_EN is defined.
module univ_shift_reg #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [2:0]   ctrl,
   input  logic         s_in_r,
   input  logic         s_in_l,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic         s_out_r,
   output logic         s_out_l,
   output logic         busy,
   output logic         done
);

   logic [N-1:0] r_q;
   logic [N-1:0] r_d;

   // Next register value for the IDLE-state modes; 111 falls through to hold here.
   always_comb begin
      r_d = r_q;
      case (ctrl)
         3'b001:  r_d = {s_in_r, r_q[N-1:1]};
         3'b010:  r_d = {r_q[N-2:0], s_in_l};
         3'b011:  r_d = d;
         3'b100:  r_d = {r_q[0], r_q[N-1:1]};
         3'b101:  r_d = {r_q[N-2:0], r_q[N-1]};
         3'b110:  r_d = {r_q[N-1], r_q[N-1:1]};
         default: r_d = r_q;
      endcase
   end

   assign q       = r_q;
   assign s_out_r = r_q[0];
   assign s_out_l = r_q[N-1];

`ifdef UNIV_SHIFT_REG_BURST_EN
   // state | meaning
   // IDLE  | ctrl selects the operation; 111 loads d and starts a burst
   // BURST | shift right with s_in_r once per enabled cycle, N times
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (en) begin
            case (state_q)
               IDLE: begin
                  if (ctrl == 3'b111) begin
                     r_q     <= d;
                     cnt_q   <= CW'(N);
                     state_q <= BURST;
                  end else begin
                     r_q <= r_d;
                  end
               end
               BURST: begin
                  r_q   <= {s_in_r, r_q[N-1:1]};
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state_q == BURST);
   assign done = done_q;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= r_d;
      end
   end

   assign busy = 1'b0;
   assign done = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (N=8) with a queue scoreboard fed by a reference model;
// burst scenarios run when UNIV_SHIFT_REG_BURST_EN is defined, otherwise 111 is checked as hold.
module tb_univ_shift_reg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] ctrl = 3'b000;
   logic       s_in_r = 1'b0;
   logic       s_in_l = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] q;
   logic       s_out_r, s_out_l, busy, done;

   univ_shift_reg #(.N(8)) dut (
      .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .s_in_r(s_in_r), .s_in_l(s_in_l),
      .d(d), .q(q), .s_out_r(s_out_r), .s_out_l(s_out_l), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t       sb[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] m_r = 8'h00;
   int         m_cnt = 0;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_r = 8'h00; m_cnt = 0; m_busy = 1'b0; m_done = 1'b0;
   endtask

   // One clock: drive inputs, push the model's prediction, pop and compare after the edge.
   task automatic step(input string tag, input logic [2:0] c, input logic e,
                       input logic [7:0] dd, input logic sr, input logic sl);
      exp_t       ex;
      exp_t       got;
      logic       nd;
      ctrl = c; en = e; d = dd; s_in_r = sr; s_in_l = sl;
      nd = 1'b0;
      if (e) begin
         if (!m_busy) begin
            case (c)
               3'b001: m_r = {sr, m_r[7:1]};
               3'b010: m_r = {m_r[6:0], sl};
               3'b011: m_r = dd;
               3'b100: m_r = {m_r[0], m_r[7:1]};
               3'b101: m_r = {m_r[6:0], m_r[7]};
               3'b110: m_r = {m_r[7], m_r[7:1]};
               3'b111: begin
`ifdef UNIV_SHIFT_REG_BURST_EN
                  m_r = dd; m_cnt = 8; m_busy = 1'b1;
`endif
               end
               default: ;
            endcase
         end else begin
            m_r = {sr, m_r[7:1]};
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy = 1'b0;
               nd = 1'b1;
            end
         end
      end
      m_done = nd;
      ex.q = m_r; ex.busy = m_busy; ex.done = m_done;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, ".q"}, q, got.q);
      chk({tag, ".s_out_r"}, s_out_r, got.q[0]);
      chk({tag, ".s_out_l"}, s_out_l, got.q[7]);
      chk({tag, ".busy"}, busy, got.busy);
      chk({tag, ".done"}, done, got.done);
   endtask

`ifdef UNIV_SHIFT_REG_BURST_EN
   // Burst of d; optional stall of stall_len cycles before shift stall_at; returns bits and busy count.
   task automatic burst(input string tag, input logic [7:0] dd, input int stall_at,
                        input int stall_len, output logic [7:0] bits, output int busy_cnt);
      busy_cnt = 0;
      bits = 8'h00;
      step({tag, ".start"}, 3'b111, 1'b1, dd, 1'b0, 1'b1);
      if (busy) busy_cnt++;
      for (int k = 0; k < 8; k++) begin
         bits[k] = s_out_r;
         if (k == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               step({tag, ".stall"}, 3'b001, 1'b0, 8'hFF, 1'b1, 1'b1);
               if (busy) busy_cnt++;
            end
         end
         step({tag, ".shift"}, (k == 3) ? 3'b011 : 3'b000, 1'b1, 8'hFF, 1'b0, 1'b1);
         if (busy) busy_cnt++;
      end
   endtask
`endif

   initial begin
      logic [7:0] bits;
      int         bc;
      rst = 1'b1; en = 1'b1; ctrl = 3'b011; d = 8'hFF; s_in_r = 1'b1; s_in_l = 1'b1;
      #12;
      chk("reset.q", q, 8'h00);
      chk("reset.busy", busy, 1'b0);
      chk("reset.done", done, 1'b0);
      chk("reset.s_out_r", s_out_r, 1'b0);
      chk("reset.s_out_l", s_out_l, 1'b0);
      rst = 1'b0;
      model_reset();

      step("load", 3'b011, 1'b1, 8'hA5, 1'b0, 1'b0);  chk("load.const", q, 8'hA5);
      step("shr", 3'b001, 1'b1, 8'h00, 1'b1, 1'b0);   chk("shr.const", q, 8'hD2);
      step("shl", 3'b010, 1'b1, 8'h00, 1'b1, 1'b0);   chk("shl.const", q, 8'hA4);
      step("en0", 3'b001, 1'b0, 8'h00, 1'b1, 1'b1);   chk("en0.const", q, 8'hA4);
      step("load81", 3'b011, 1'b1, 8'h81, 1'b0, 1'b0);
      step("ror", 3'b100, 1'b1, 8'h00, 1'b0, 1'b0);   chk("ror.const", q, 8'hC0);
      step("rol1", 3'b101, 1'b1, 8'h00, 1'b0, 1'b0);  chk("rol1.const", q, 8'h81);
      step("rol2", 3'b101, 1'b1, 8'h00, 1'b0, 1'b0);  chk("rol2.const", q, 8'h03);
      step("load80", 3'b011, 1'b1, 8'h80, 1'b0, 1'b0);
      step("asr1", 3'b110, 1'b1, 8'h00, 1'b0, 1'b0);  chk("asr1.const", q, 8'hC0);
      step("asr2", 3'b110, 1'b1, 8'h00, 1'b0, 1'b0);  chk("asr2.const", q, 8'hE0);
      step("asr3", 3'b110, 1'b1, 8'h00, 1'b0, 1'b0);  chk("asr3.const", q, 8'hF0);

`ifdef UNIV_SHIFT_REG_BURST_EN
      burst("b1", 8'h5A, -1, 0, bits, bc);
      chk("b1.bits", bits, 8'h5A);
      chk("b1.busy_cycles", bc, 8);
      chk("b1.done", done, 1'b1);
      chk("b1.final_q", q, 8'h00);

      burst("b2", 8'hC3, 4, 2, bits, bc);
      chk("b2.bits", bits, 8'hC3);
      chk("b2.busy_cycles", bc, 10);
      chk("b2.done", done, 1'b1);

      step("b3.start_in_done", 3'b111, 1'b1, 8'h96, 1'b1, 1'b0);
      chk("b3.accepted", busy, 1'b1);
      step("b3.restart_ignored", 3'b111, 1'b1, 8'h00, 1'b1, 1'b0);
      step("b3.s2", 3'b000, 1'b1, 8'h00, 1'b1, 1'b0);
      step("b3.s3", 3'b000, 1'b1, 8'h00, 1'b1, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("rst_mid.q", q, 8'h00);
      chk("rst_mid.busy", busy, 1'b0);
      chk("rst_mid.done", done, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) step("rst_mid.idle", 3'b000, 1'b1, 8'h00, 1'b1, 1'b0);
      step("rst_mid.load", 3'b011, 1'b1, 8'h3C, 1'b0, 1'b0);
      chk("rst_mid.load.const", q, 8'h3C);
`else
      step("nb.ctrl111", 3'b111, 1'b1, 8'h5A, 1'b1, 1'b1);
      chk("nb.hold.const", q, 8'hF0);
      chk("nb.busy.const", busy, 1'b0);
      step("nb.load", 3'b011, 1'b1, 8'h3C, 1'b0, 1'b0);
      chk("nb.load.const", q, 8'h3C);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, next generation of the team's 4-mode shift register. It adds left shift, rotate, arithmetic shift, a clock enable and an autonomous burst mode. Burst mode loads a word and serialises it LSB-first over N cycles with busy/done status. It sits between parallel datapaths and bit-serial links, for example as a serialiser in front of an SPI-style transmitter.

## Interface
- N, default 8, register width in bits; N ≥ 2.
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous, active-high
- en  in  1  clock enable; gates every state update, including the burst counter
- ctrl  in  3  mode select, see Operation
- s_in_r  in  1  serial input entering at MSB on right shift / arithmetic-free shifts / burst
- s_in_l  in  1  serial input entering at LSB on left shift
- d  in  N  parallel load data
- q  out  N  register contents
- s_out_r  out  1  r[0], right-shift serial output
- s_out_l  out  1  r[N-1], left-shift serial output
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the final burst shift

## Operation
- State: register r[N-1:0], counter cnt of width $clog2(N+1), busy, done. Two states: IDLE (busy=0) and BURST (busy=1).
- IDLE, en=1, next r by ctrl:
  - 000: hold.
  - 001: shift right, {s_in_r, r[N-1:1]}.
  - 010: shift left, {r[N-2:0], s_in_l}.
  - 011: load, d.
  - 100: rotate right, {r[0], r[N-1:1]}.
  - 101: rotate left, {r[N-2:0], r[N-1]}.
  - 110: arithmetic shift right, {r[N-1], r[N-1:1]}.
  - 111: burst start. r<=d, cnt<=N, busy<=1; go to BURST.
- BURST, en=1: r shifts right with s_in_r, cnt<=cnt-1. When cnt==1 this is the last shift: busy<=0, done<=1, return to IDLE.
- BURST ignores ctrl, d and s_in_l. ctrl=111 while busy does not restart the burst.
- en=0: r, cnt and busy hold in any state. A burst stalls and does not complete.
- done is a single-cycle pulse. It clears at the next clock edge regardless of en.
- A burst start is accepted in the cycle done is high, because busy is already 0.
- Outputs: q, s_out_r and s_out_l derive directly from r with no additional logic depth. busy and done are registered.

## Timing
- Reset values: q=0, s_out_r=0, s_out_l=0, busy=0, done=0, cnt=0. Reset is effective immediately, mid-burst included; the block returns to IDLE.
- All modes have 1-cycle latency: the result is visible on q after the accepting edge.
- Burst accepted at edge E0: during enabled cycle k (k=0..N-1) after E0, s_out_r = d[k].
- busy is high for exactly N enabled cycles after E0, plus one cycle per stalled (en=0) cycle.
- done is high for the single cycle after the N-th shift.
- After the burst, q = N copies of s_in_r if s_in_r was held constant.

## Configuration
- Macro UNIV_SHIFT_REG_BURST_EN.
- Defined: burst mode present as specified.
- Undefined: ctrl=111 behaves as hold, no counter is built, and busy and done are tied to 0. All other modes are unchanged.

## Test plan
- Reset: assert rst with arbitrary inputs -> q=0x00, busy=0, done=0, s_out_r=0, s_out_l=0.
- N=8: load 0xA5, then shift right with s_in_r=1, then shift left with s_in_l=0 -> q=0xA5, then 0xD2, then 0xA4. en=0 during a shift -> q unchanged.
- Load 0x81, rotate right -> 0xC0; rotate left twice -> 0x81, then 0x03. Load 0x80, arithmetic shift right ×3 -> 0xC0, 0xE0, 0xF0.
- Burst with d=0x5A, s_in_r=0:
  - s_out_r over cycles 0..7 = 0,1,0,1,1,0,1,0.
  - busy high 8 cycles; done high 1 cycle after; final q=0x00.
  - ctrl=011 mid-burst -> ignored.
- Burst with en=0 for 2 cycles mid-burst -> busy high 10 cycles, bit sequence unchanged, no duplicated or skipped bits. Second burst started in the done cycle -> accepted.
- Assert rst at burst cycle 3 -> q=0x00, busy=0, done never asserted. Next ctrl=011 with d=0x3C -> q=0x3C.
